// File: rtl/cpu_clock_step_ctrl.sv
// cpu_clock_step_ctrl
//   Clock-step and reset front end for the turtle CPU. Raw board inputs are
//   synchronized and debounced. The block then issues a single-cycle step
//   strobe, either at a divided rate (auto mode) or once per button press
//   (manual mode). It also drives a stretched, registered CPU reset.
//
// Parameters
//   DEBOUNCE_CYCLES      consecutive stable cycles before a conditioned input changes
//   AUTO_DIV             clocks per step in auto mode
//   RESET_STRETCH_CYCLES cpu_reset_n low time after reset is released
//
// Ports
//   clk            in   board clock
//   reset_n        in   asynchronous active-low reset
//   reset_btn      in   raw reset button, active-high
//   manual_clk_sw  in   raw mode switch (0 = auto, 1 = manual)
//   pulse_clk_btn  in   raw step button, active-high
//   cpu_clk_en     out  single-cycle step strobe
//   cpu_reset_n    out  registered active-low CPU reset
//   manual_mode    out  debounced mode indication
//   step_count     out  step strobes since the last CPU reset (wraps)
module cpu_clock_step_ctrl #(
    parameter int DEBOUNCE_CYCLES      = 250000,
    parameter int AUTO_DIV             = 1000,
    parameter int RESET_STRETCH_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reset_btn,
    input  logic        manual_clk_sw,
    input  logic        pulse_clk_btn,
    output logic        cpu_clk_en,
    output logic        cpu_reset_n,
    output logic        manual_mode,
    output logic [15:0] step_count
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PS_W = $clog2(AUTO_DIV + 1);
    localparam int ST_W = $clog2(RESET_STRETCH_CYCLES + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(AUTO_DIV - 1);
    localparam logic [ST_W-1:0] ST_LOAD = ST_W'(RESET_STRETCH_CYCLES);

    typedef enum logic [1:0] {
        RESET_HOLD,
        RUN_AUTO,
        RUN_MANUAL
    } state_t;

    // Bit 0: reset button, bit 1: mode switch, bit 2: step button.
    logic [2:0] raw_in;
    logic [2:0] db_value;

    assign raw_in = {pulse_clk_btn, manual_clk_sw, reset_btn};

    // Per-input 2-FF synchronizer followed by a counting debouncer. The
    // stable value flips on the DEBOUNCE_CYCLES-th consecutive mismatching
    // cycle. Any agreeing cycle restarts the count.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cond
            logic            sync1_reg;
            logic            sync2_reg;
            logic            stable_reg;
            logic [DB_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync1_reg  <= 1'b0;
                    sync2_reg  <= 1'b0;
                    stable_reg <= 1'b0;
                    cnt_reg    <= '0;
                end else begin
                    sync1_reg <= raw_in[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == stable_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        stable_reg <= sync2_reg;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + DB_W'(1);
                    end
                end
            end

            assign db_value[gi] = stable_reg;
        end
    endgenerate

    logic db_reset;
    logic db_mode;
    logic db_pulse;

    assign db_reset = db_value[0];
    assign db_mode  = db_value[1];
    assign db_pulse = db_value[2];

    // Registered rising-edge detect on the debounced step button.
    logic pulse_prev_reg;
    logic step_req_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_prev_reg <= 1'b0;
            step_req_reg   <= 1'b0;
        end else begin
            pulse_prev_reg <= db_pulse;
            step_req_reg   <= db_pulse & ~pulse_prev_reg;
        end
    end

    state_t          state_reg,   state_next;
    logic [PS_W-1:0] presc_reg,   presc_next;
    logic [ST_W-1:0] stretch_reg, stretch_next;
    logic            clk_en_next;
    logic            cpu_clk_en_reg;
    logic            cpu_reset_n_reg;
    logic [15:0]     step_count_reg;

    always_comb begin
        state_next   = state_reg;
        presc_next   = presc_reg;
        stretch_next = stretch_reg;
        clk_en_next  = 1'b0;

        // The stretch counter is reloaded for as long as the button is held,
        // so the low time is measured from the debounced release.
        if (db_reset) begin
            stretch_next = ST_LOAD;
        end

        case (state_reg)
            RESET_HOLD: begin
                presc_next = '0;
                if (!db_reset) begin
                    if (stretch_reg != '0) begin
                        stretch_next = stretch_reg - ST_W'(1);
                    end
                    if (stretch_next == '0) begin
                        state_next = db_mode ? RUN_MANUAL : RUN_AUTO;
                    end
                end
            end
            RUN_AUTO: begin
                if (db_reset) begin
                    state_next = RESET_HOLD;
                    presc_next = '0;
                end else if (db_mode) begin
                    state_next = RUN_MANUAL;
                    presc_next = '0;
                end else if (presc_reg == PS_LAST) begin
                    presc_next  = '0;
                    clk_en_next = 1'b1;
                end else begin
                    presc_next = presc_reg + PS_W'(1);
                end
            end
            RUN_MANUAL: begin
                presc_next = '0;
                if (db_reset) begin
                    state_next = RESET_HOLD;
                end else if (!db_mode) begin
                    state_next = RUN_AUTO;
                end else begin
                    clk_en_next = step_req_reg;
                end
            end
            default: begin
                state_next = RESET_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= RESET_HOLD;
            presc_reg       <= '0;
            stretch_reg     <= ST_LOAD;
            cpu_clk_en_reg  <= 1'b0;
            cpu_reset_n_reg <= 1'b0;
            step_count_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            presc_reg       <= presc_next;
            stretch_reg     <= stretch_next;
            cpu_clk_en_reg  <= clk_en_next;
            cpu_reset_n_reg <= (state_next != RESET_HOLD);
            // The count includes the strobe issued on this same edge.
            if (state_next == RESET_HOLD) begin
                step_count_reg <= '0;
            end else begin
                step_count_reg <= step_count_reg + {15'd0, clk_en_next};
            end
        end
    end

    assign cpu_clk_en  = cpu_clk_en_reg;
    assign cpu_reset_n = cpu_reset_n_reg;
    assign manual_mode = db_mode;
    assign step_count  = step_count_reg;

endmodule

// File: tb/tb_cpu_clock_step_ctrl.sv
// Directed bench for cpu_clock_step_ctrl. The main instance uses
// DEBOUNCE_CYCLES=4, AUTO_DIV=3, RESET_STRETCH_CYCLES=8. A second instance
// uses DEBOUNCE_CYCLES=1, AUTO_DIV=1, RESET_STRETCH_CYCLES=1. It free-runs
// to exercise the step_count wrap and the every-cycle auto strobe.
module tb_cpu_clock_step_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        reset_btn;
    logic        manual_clk_sw;
    logic        pulse_clk_btn;
    logic        cpu_clk_en;
    logic        cpu_reset_n;
    logic        manual_mode;
    logic [15:0] step_count;

    logic        w_reset_n;
    logic        w_reset_btn;
    logic        w_manual_clk_sw;
    logic        w_pulse_clk_btn;
    logic        w_cpu_clk_en;
    logic        w_cpu_reset_n;
    logic        w_manual_mode;
    logic [15:0] w_step_count;

    cpu_clock_step_ctrl #(
        .DEBOUNCE_CYCLES     (4),
        .AUTO_DIV            (3),
        .RESET_STRETCH_CYCLES(8)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .reset_btn    (reset_btn),
        .manual_clk_sw(manual_clk_sw),
        .pulse_clk_btn(pulse_clk_btn),
        .cpu_clk_en   (cpu_clk_en),
        .cpu_reset_n  (cpu_reset_n),
        .manual_mode  (manual_mode),
        .step_count   (step_count)
    );

    cpu_clock_step_ctrl #(
        .DEBOUNCE_CYCLES     (1),
        .AUTO_DIV            (1),
        .RESET_STRETCH_CYCLES(1)
    ) u_wrap (
        .clk          (clk),
        .reset_n      (w_reset_n),
        .reset_btn    (w_reset_btn),
        .manual_clk_sw(w_manual_clk_sw),
        .pulse_clk_btn(w_pulse_clk_btn),
        .cpu_clk_en   (w_cpu_clk_en),
        .cpu_reset_n  (w_cpu_reset_n),
        .manual_mode  (w_manual_mode),
        .step_count   (w_step_count)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int unsigned base;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clean press: 8 cycles high, 8 low. The strobe lands 8 edges after
    // the press is driven (6 to debounce, +1 step_req, +1 strobe).
    task automatic press_checked();
        pulse_clk_btn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("press_en", cpu_clk_en, (i == 8));
        end
        pulse_clk_btn = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("release_en", cpu_clk_en, 0);
        end
    endtask

    initial begin
        reset_n         = 1'b0;
        reset_btn       = 1'b0;
        manual_clk_sw   = 1'b0;
        pulse_clk_btn   = 1'b0;
        w_reset_n       = 1'b0;
        w_reset_btn     = 1'b0;
        w_manual_clk_sw = 1'b0;
        w_pulse_clk_btn = 1'b0;

        // Reset values.
        repeat (3) tick();
        chk("rst_cpu_reset_n", cpu_reset_n, 0);
        chk("rst_clk_en", cpu_clk_en, 0);
        chk("rst_manual", manual_mode, 0);
        chk("rst_step", step_count, 0);
        chk("wrap_rst_reset_n", w_cpu_reset_n, 0);

        // Release both instances; stretch, then auto strobes every 3rd cycle.
        reset_n   = 1'b1;
        w_reset_n = 1'b1;
        base      = cyc;
        for (int k = 1; k <= 23; k++) begin
            tick();
            chk("stretch_reset_n", cpu_reset_n, (k >= 8));
            chk("auto_en", cpu_clk_en, (k >= 9) && ((k - 8) % 3 == 0));
            chk("auto_step", step_count, (k >= 8) ? (k - 8) / 3 : 0);
            if (k == 1) begin
                chk("wrap_reset_n_e1", w_cpu_reset_n, 1);
                chk("wrap_en_e1", w_cpu_clk_en, 0);
            end
            if (k == 2) begin
                chk("wrap_en_e2", w_cpu_clk_en, 1);
                chk("wrap_step_e2", w_step_count, 1);
            end
        end
        chk("auto_step_5", step_count, 5);

        // Switch to manual: mode rises on the 6th edge; auto stops after it.
        manual_clk_sw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("mode_rise", manual_mode, (i >= 6));
            chk("mode_switch_en", cpu_clk_en, (i == 3) || (i == 6));
        end
        chk("mode_step", step_count, 7);

        // Three clean presses.
        for (int p = 0; p < 3; p++) press_checked();
        chk("press_step", step_count, 10);

        // Bouncy press: high 2, low 1, then high; exactly one strobe.
        pulse_clk_btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("bounce_en", cpu_clk_en, (i == 11));
            if (i == 2) pulse_clk_btn = 1'b0;
            if (i == 3) pulse_clk_btn = 1'b1;
        end
        pulse_clk_btn = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("bounce_release_en", cpu_clk_en, 0);
        end
        // 3-cycle glitch: no strobe.
        pulse_clk_btn = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("glitch_en", cpu_clk_en, 0);
            if (i == 3) pulse_clk_btn = 1'b0;
        end
        chk("glitch_step", step_count, 11);

        // Reset button held 10 cycles.
        reset_btn = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (i == 10) reset_btn = 1'b0;
            chk("btn_reset_n", cpu_reset_n, (i <= 6) || (i >= 24));
            chk("btn_step", step_count, (i <= 6) ? 11 : 0);
            chk("btn_en", cpu_clk_en, 0);
        end
        chk("btn_manual", manual_mode, 1);

        // Reach step_count 0x0042 in manual mode, then async reset.
        for (int p = 0; p < 66; p++) begin
            pulse_clk_btn = 1'b1;
            repeat (8) tick();
            pulse_clk_btn = 1'b0;
            repeat (8) tick();
        end
        chk("pre_async_step", step_count, 16'h0042);
        chk("pre_async_manual", manual_mode, 1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_reset_n", cpu_reset_n, 0);
        chk("async_en", cpu_clk_en, 0);
        chk("async_manual", manual_mode, 0);
        chk("async_step", step_count, 0);
        manual_clk_sw = 1'b0;

        // Wrap: the second instance has step_count = k-1 after edge k.
        while (cyc - base < 32'd65536) tick();
        chk("wrap_ffff", w_step_count, 16'hFFFF);
        chk("wrap_en_ffff", w_cpu_clk_en, 1);
        tick();
        chk("wrap_0000", w_step_count, 16'h0000);
        chk("wrap_en_0000", w_cpu_clk_en, 1);
        tick();
        chk("wrap_0001", w_step_count, 16'h0001);
        chk("held_reset_n", cpu_reset_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_clock_step_ctrl.md
# cpu_clock_step_ctrl

Front-end clock-step and reset controller for the turtle CPU, sitting directly upstream of `turtle_cpu_top`. It conditions the board inputs (`reset_btn`, `manual_clk_sw`, `pulse_clk_btn`) and produces the CPU's step enable and core reset. The CPU either free-runs at a divided rate or advances exactly one instruction per debounced button press. All logic runs on the single board clock; the CPU pipeline is gated by `cpu_clk_en`.

## Interface
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required before a conditioned input changes; ≥1.
- `AUTO_DIV`, default 1000: auto mode issues one step per `AUTO_DIV` clocks; ≥1.
- `RESET_STRETCH_CYCLES`, default 16: `cpu_reset_n` low time after reset release; ≥1.
- `clk`  in  1  board clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `reset_btn`  in  1  raw button, active-high, asynchronous to `clk`.
- `manual_clk_sw`  in  1  raw switch: 0 selects auto mode, 1 selects manual mode.
- `pulse_clk_btn`  in  1  raw button, active-high; one CPU step per press in manual mode.
- `cpu_clk_en`  out  1  single-cycle step strobe to the CPU.
- `cpu_reset_n`  out  1  registered, active-low CPU reset.
- `manual_mode`  out  1  debounced mode indication.
- `step_count`  out  16  number of `cpu_clk_en` pulses since the last CPU reset.

## Operation
- Each raw input passes through a 2-FF synchronizer, then an independent debouncer.
- Debouncer behaviour:
  - The counter increments while the synchronized value differs from the stable value.
  - The counter clears when the two agree.
  - At `DEBOUNCE_CYCLES` consecutive mismatching cycles, the stable value flips and the counter clears.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- A registered edge detector on debounced `pulse_clk_btn` yields `step_req` for one cycle on a 0→1 transition. Release (1→0) produces nothing.
- FSM states:
  - RESET_HOLD: `cpu_reset_n`=0, `cpu_clk_en`=0, prescaler and `step_count` cleared. The stretch counter loads `RESET_STRETCH_CYCLES` while debounced reset is 1, and decrements otherwise. At 0 the FSM goes to RUN_AUTO if `manual_mode`=0, else RUN_MANUAL.
  - RUN_AUTO: prescaler counts 0..`AUTO_DIV`-1 and wraps. `cpu_clk_en`=1 in the cycle the count equals `AUTO_DIV`-1. `AUTO_DIV`=1 gives `cpu_clk_en` every cycle.
  - RUN_MANUAL: `cpu_clk_en`=1 for exactly one cycle per `step_req`. The prescaler is held at 0.
  - From either RUN state, debounced reset = 1 goes to RESET_HOLD, and `cpu_clk_en` is forced 0 in that same cycle.
  - A debounced mode change switches between RUN_AUTO and RUN_MANUAL and clears the prescaler. No `cpu_clk_en` is issued in the transition cycle.
- `step_req` arriving in RUN_AUTO or RESET_HOLD is discarded, not queued.
- `step_count` increments on every `cpu_clk_en` pulse, wraps 0xFFFF→0x0000, and is cleared in RESET_HOLD.
- `manual_mode` is the debounced `manual_clk_sw`, registered.

## Timing
- On `reset_n` low (asynchronous): state = RESET_HOLD, `cpu_reset_n`=0, `cpu_clk_en`=0, `manual_mode`=0, `step_count`=0, all debounced values 0, all counters 0, stretch counter = `RESET_STRETCH_CYCLES`.
- After `reset_n` release with reset_btn low, `cpu_reset_n` rises after exactly `RESET_STRETCH_CYCLES` clocks.
- Input-to-debounced latency: 2 (sync) + `DEBOUNCE_CYCLES` clocks after the first edge that samples the new raw value.
- Press-to-step latency in manual mode: debounced rise, then +1 clock for `step_req`, then +1 clock for `cpu_clk_en`.
- First auto `cpu_clk_en` arrives `AUTO_DIV` clocks after entering RUN_AUTO.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronized cycles produce no output change.
- All outputs are registered.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `AUTO_DIV`=3, `RESET_STRETCH_CYCLES`=8.
- Release `reset_n`, all inputs 0 → `cpu_reset_n` stays 0 for 8 cycles. After that, `cpu_clk_en` pulses every 3rd cycle, and `step_count` reads 5 after 5 pulses.
- `manual_clk_sw`=1 held 10 cycles → `manual_mode` rises 6 cycles after the input change and auto pulses stop. Then 3 clean `pulse_clk_btn` presses of 8 cycles each → exactly 3 single-cycle `cpu_clk_en` pulses, `step_count` +3.
- In manual mode, `pulse_clk_btn` bounces high 2 cycles, low 1, high 2, then stays high → exactly 1 `cpu_clk_en`. A 3-cycle-only pulse → 0 pulses.
- `reset_btn` pressed mid-run for 10 cycles → `cpu_clk_en`=0 from the cycle debounced reset rises, `step_count`=0, `cpu_reset_n` returns high 8 cycles after debounced release.
- Assert `reset_n` while in RUN_MANUAL with `step_count`=0x0042 → all outputs take their reset values immediately.
- 65536 auto pulses from a fresh reset → `step_count` wraps to 0x0000 with no stall.
